// File: rtl/jtag_tap_multi.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_multi
// Purpose  : IEEE 1149.1 TAP controller with a configurable instruction
//            register length, built-in IDCODE and BYPASS registers, and N
//            user data registers decoded from a contiguous opcode range.
//            Everything runs in the tck domain.
// Ports    : tck_i / trst_ni       JTAG clock, synchronous active-low reset
//            tms_i / td_i / td_o   JTAG pins, tdo_oe_o marks td_o valid
//            tdi_o                 serial data passthrough to user DRs
//            capture_o/shift_o/update_o  Capture/Shift/Update-DR strobes
//            dr_clear_o / run_test_idle_o  TLR / RTI status
//            ir_o                  current instruction
//            dr_select_o / dr_tdo_i  one-hot user DR select, user DR serial out
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_multi #(
    parameter int unsigned IrLength    = 5,
    parameter logic [31:0] IdCodeValue = 32'h0000_0001,
    parameter int unsigned IrIdcode    = 'h01,
    parameter int unsigned UserIrBase  = 'h10,
    parameter int unsigned NumUserDr   = 2
) (
    input  logic                 tck_i,
    input  logic                 trst_ni,
    input  logic                 tms_i,
    input  logic                 td_i,
    output logic                 td_o,
    output logic                 tdo_oe_o,
    output logic                 tdi_o,
    output logic                 capture_o,
    output logic                 shift_o,
    output logic                 update_o,
    output logic                 dr_clear_o,
    output logic                 run_test_idle_o,
    output logic [IrLength-1:0]  ir_o,
    output logic [NumUserDr-1:0] dr_select_o,
    input  logic [NumUserDr-1:0] dr_tdo_i
);

    localparam logic [3:0] c_st_exit2_dr  = 4'h0;
    localparam logic [3:0] c_st_exit1_dr  = 4'h1;
    localparam logic [3:0] c_st_shift_dr  = 4'h2;
    localparam logic [3:0] c_st_pause_dr  = 4'h3;
    localparam logic [3:0] c_st_sel_ir    = 4'h4;
    localparam logic [3:0] c_st_update_dr = 4'h5;
    localparam logic [3:0] c_st_cap_dr    = 4'h6;
    localparam logic [3:0] c_st_sel_dr    = 4'h7;
    localparam logic [3:0] c_st_exit2_ir  = 4'h8;
    localparam logic [3:0] c_st_exit1_ir  = 4'h9;
    localparam logic [3:0] c_st_shift_ir  = 4'hA;
    localparam logic [3:0] c_st_pause_ir  = 4'hB;
    localparam logic [3:0] c_st_rti       = 4'hC;
    localparam logic [3:0] c_st_update_ir = 4'hD;
    localparam logic [3:0] c_st_cap_ir    = 4'hE;
    localparam logic [3:0] c_st_tlr       = 4'hF;

    localparam int unsigned c_user_last = UserIrBase + NumUserDr - 1;
    localparam int unsigned c_ir_ones   = (32'd1 << IrLength) - 32'd1;

    // Reject parameter sets whose user opcode range overflows the IR, overlaps
    // IDCODE or claims the all-ones BYPASS opcode.
    if (IrLength < 2 || IrLength > 31 || NumUserDr < 1 || NumUserDr > 8 ||
        c_user_last > c_ir_ones || c_user_last == c_ir_ones ||
        (IrIdcode >= UserIrBase && IrIdcode <= c_user_last) ||
        IrIdcode > c_ir_ones || IdCodeValue[0] != 1'b1) begin : g_param_check
        $error("jtag_tap_multi: illegal parameter combination");
    end

    logic [3:0]           r_state;
    logic [3:0]           w_next;
    logic [IrLength-1:0]  r_ir;
    logic [IrLength-1:0]  r_ir_shift;
    logic [IrLength-1:0]  w_ir;
    logic [31:0]          r_idcode;
    logic                 r_bypass;
    logic [NumUserDr-1:0] w_sel;
    logic                 w_idcode_sel;
    logic                 w_bypass_sel;

    // ---------------- state register ----------------
    always_ff @(posedge tck_i) begin
        if (!trst_ni) begin
            r_state <= c_st_tlr;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_tlr:       w_next = tms_i ? c_st_tlr       : c_st_rti;
            c_st_rti:       w_next = tms_i ? c_st_sel_dr    : c_st_rti;
            c_st_sel_dr:    w_next = tms_i ? c_st_sel_ir    : c_st_cap_dr;
            c_st_cap_dr:    w_next = tms_i ? c_st_exit1_dr  : c_st_shift_dr;
            c_st_shift_dr:  w_next = tms_i ? c_st_exit1_dr  : c_st_shift_dr;
            c_st_exit1_dr:  w_next = tms_i ? c_st_update_dr : c_st_pause_dr;
            c_st_pause_dr:  w_next = tms_i ? c_st_exit2_dr  : c_st_pause_dr;
            c_st_exit2_dr:  w_next = tms_i ? c_st_update_dr : c_st_shift_dr;
            c_st_update_dr: w_next = tms_i ? c_st_sel_dr    : c_st_rti;
            c_st_sel_ir:    w_next = tms_i ? c_st_tlr       : c_st_cap_ir;
            c_st_cap_ir:    w_next = tms_i ? c_st_exit1_ir  : c_st_shift_ir;
            c_st_shift_ir:  w_next = tms_i ? c_st_exit1_ir  : c_st_shift_ir;
            c_st_exit1_ir:  w_next = tms_i ? c_st_update_ir : c_st_pause_ir;
            c_st_pause_ir:  w_next = tms_i ? c_st_exit2_ir  : c_st_pause_ir;
            c_st_exit2_ir:  w_next = tms_i ? c_st_update_ir : c_st_shift_ir;
            c_st_update_ir: w_next = tms_i ? c_st_sel_dr    : c_st_rti;
            default:        w_next = c_st_tlr;
        endcase
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        capture_o       = 1'b0;
        shift_o         = 1'b0;
        update_o        = 1'b0;
        dr_clear_o      = 1'b0;
        run_test_idle_o = 1'b0;
        tdo_oe_o        = 1'b0;
        case (r_state)
            c_st_cap_dr:    capture_o       = 1'b1;
            c_st_shift_dr:  begin
                shift_o  = 1'b1;
                tdo_oe_o = 1'b1;
            end
            c_st_update_dr: update_o        = 1'b1;
            c_st_tlr:       dr_clear_o      = 1'b1;
            c_st_rti:       run_test_idle_o = 1'b1;
            c_st_shift_ir:  tdo_oe_o        = 1'b1;
            default:        ;
        endcase
    end

    // IR reads as IDCODE for the whole TLR stay, including the first cycle
    // after entering TLR via TMS before r_ir has been reloaded.
    assign w_ir  = (r_state == c_st_tlr) ? IrLength'(IrIdcode) : r_ir;
    assign ir_o  = w_ir;
    assign tdi_o = td_i;

    for (genvar k = 0; k < NumUserDr; k++) begin : g_sel
        assign w_sel[k] = (w_ir == IrLength'(UserIrBase + k));
    end

    assign dr_select_o  = w_sel;
    assign w_idcode_sel = (w_ir == IrLength'(IrIdcode));
    assign w_bypass_sel = !w_idcode_sel && !(|w_sel);

    // ---------------- IR, IDCODE and BYPASS datapath ----------------
    always_ff @(posedge tck_i) begin
        if (!trst_ni || r_state == c_st_tlr) begin
            r_ir       <= IrLength'(IrIdcode);
            r_ir_shift <= '0;
            r_idcode   <= '0;
            r_bypass   <= 1'b0;
        end else begin
            case (r_state)
                c_st_cap_ir:    r_ir_shift <= IrLength'(1);
                c_st_shift_ir:  r_ir_shift <= {td_i, r_ir_shift[IrLength-1:1]};
                c_st_update_ir: r_ir       <= r_ir_shift;
                c_st_cap_dr: begin
                    if (w_idcode_sel) r_idcode <= IdCodeValue;
                    if (w_bypass_sel) r_bypass <= 1'b0;
                end
                c_st_shift_dr: begin
                    if (w_idcode_sel) r_idcode <= {td_i, r_idcode[31:1]};
                    if (w_bypass_sel) r_bypass <= td_i;
                end
                default: ;
            endcase
        end
    end

    // ---------------- serial output mux ----------------
    always_comb begin
        td_o = 1'b0;
        if (r_state == c_st_shift_ir) begin
            td_o = r_ir_shift[0];
        end else if (r_state == c_st_shift_dr) begin
            if (w_idcode_sel)      td_o = r_idcode[0];
            else if (|w_sel)       td_o = |(w_sel & dr_tdo_i);
            else                   td_o = r_bypass;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_tap_multi
// Purpose  : Directed self-checking bench for jtag_tap_multi. Instance A uses
//            the default geometry with IDCODE 0xDEADBEEF; instance B is the
//            8-bit-IR / 4-user-DR variant. Both share the JTAG pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_multi;

    logic       tck = 1'b0;
    logic       trst_n = 1'b0;
    logic       tms = 1'b1;
    logic       td = 1'b0;

    logic       tdo_a, oe_a, tdi_a, cap_a, sh_a, upd_a, clr_a, rti_a;
    logic [4:0] ir_a;
    logic [1:0] sel_a;
    logic [1:0] dr_tdo_a = '0;

    logic       tdo_b, oe_b, tdi_b, cap_b, sh_b, upd_b, clr_b, rti_b;
    logic [7:0] ir_b;
    logic [3:0] sel_b;
    logic [3:0] dr_tdo_b = '0;

    int n_cmp = 0;
    int n_err = 0;
    int n_upd_a = 0;

    logic [63:0] dout;
    logic [63:0] dout2;

    always #5 tck = ~tck;

    jtag_tap_multi #(
        .IrLength(5), .IdCodeValue(32'hDEAD_BEEF), .IrIdcode('h01),
        .UserIrBase('h10), .NumUserDr(2)
    ) u_dut_a (
        .tck_i(tck), .trst_ni(trst_n), .tms_i(tms), .td_i(td),
        .td_o(tdo_a), .tdo_oe_o(oe_a), .tdi_o(tdi_a), .capture_o(cap_a),
        .shift_o(sh_a), .update_o(upd_a), .dr_clear_o(clr_a),
        .run_test_idle_o(rti_a), .ir_o(ir_a), .dr_select_o(sel_a),
        .dr_tdo_i(dr_tdo_a)
    );

    jtag_tap_multi #(
        .IrLength(8), .IdCodeValue(32'hCAFE_F00D), .IrIdcode('h01),
        .UserIrBase('h20), .NumUserDr(4)
    ) u_dut_b (
        .tck_i(tck), .trst_ni(trst_n), .tms_i(tms), .td_i(td),
        .td_o(tdo_b), .tdo_oe_o(oe_b), .tdi_o(tdi_b), .capture_o(cap_b),
        .shift_o(sh_b), .update_o(upd_b), .dr_clear_o(clr_b),
        .run_test_idle_o(rti_b), .ir_o(ir_b), .dr_select_o(sel_b),
        .dr_tdo_i(dr_tdo_b)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One rising edge with the given pin values; outputs settle 1 ns later.
    task automatic step(input logic t_ms, input logic t_di);
        tms = t_ms;
        td  = t_di;
        @(posedge tck);
        #1;
        if (upd_a) n_upd_a++;
    endtask

    // Shift n bits from the current Shift state, LSB first. pat drives the
    // selected user DR serial output; unselected bits carry the inverse.
    task automatic shift(input bit use_b, input int n, input logic [63:0] din,
                         input logic [63:0] pat, input bit exit_last,
                         output logic [63:0] q);
        q = '0;
        for (int i = 0; i < n; i++) begin
            dr_tdo_a = {pat[i], ~pat[i]};
            dr_tdo_b = {pat[i], ~pat[i], ~pat[i], ~pat[i]};
            #1;
            q[i] = use_b ? tdo_b : tdo_a;
            step(exit_last && (i == n - 1), din[i]);
        end
    endtask

    // RTI -> Shift-IR -> n bits -> Update-IR -> RTI
    task automatic ir_scan(input bit use_b, input int n, input logic [63:0] din,
                           output logic [63:0] q);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        shift(use_b, n, din, '0, 1'b1, q);
        step(1, 0); step(0, 0);
    endtask

    // RTI -> Shift-DR -> n bits -> Update-DR -> RTI
    task automatic dr_scan(input bit use_b, input int n, input logic [63:0] din,
                           input logic [63:0] pat, output logic [63:0] q);
        step(1, 0); step(0, 0); step(0, 0);
        shift(use_b, n, din, pat, 1'b1, q);
        step(1, 0); step(0, 0);
    endtask

    initial begin
        // Reset held over two edges.
        step(1, 0);
        step(1, 0);
        check("rst_dr_clear", clr_a, 1);
        check("rst_ir", ir_a, 5'h01);
        check("rst_sel", sel_a, 0);
        check("rst_rti", rti_a, 0);
        check("rst_oe", oe_a, 0);
        trst_n = 1'b1;
        step(0, 0);
        check("rti_state", rti_a, 1);
        check("rti_dr_clear", clr_a, 0);
        check("rti_ir", ir_a, 5'h01);

        // IDCODE scan; also look at the Capture-DR and Shift-DR strobes.
        step(1, 0);
        step(0, 0);
        check("capture_strobe", cap_a, 1);
        step(0, 0);
        check("shift_strobe", {sh_a, oe_a}, 2'b11);
        shift(0, 32, '0, '0, 1'b1, dout);
        step(1, 0); step(0, 0);
        check("idcode_a", dout, 64'hDEAD_BEEF);

        // Select user DR 1 and scan it with a toggling backend output.
        ir_scan(0, 5, 64'h11, dout);
        check("ir_capture_bits", dout, 64'h01);
        check("ir_11", ir_a, 5'h11);
        check("sel_dr1", sel_a, 2'b10);
        n_upd_a = 0;
        dr_scan(0, 41, '0, 64'h1A5_C3F0_96E1, dout);
        check("user_dr1_tdo", dout, 64'h1A5_C3F0_96E1);
        check("update_pulses", n_upd_a, 1);

        // All-ones and an unassigned opcode both fall into BYPASS.
        ir_scan(0, 5, 64'h1F, dout);
        check("ir_1f", ir_a, 5'h1F);
        check("sel_1f", sel_a, 0);
        dr_scan(0, 5, 64'h0B, '0, dout);
        check("bypass_1f", dout, 64'h16);
        ir_scan(0, 5, 64'h07, dout);
        check("sel_07", sel_a, 0);
        dr_scan(0, 5, 64'h0B, '0, dout);
        check("bypass_07", dout, 64'h16);

        // Abort a DR scan with five TMS=1.
        ir_scan(0, 5, 64'h11, dout);
        step(1, 0); step(0, 0); step(0, 0);
        shift(0, 3, 64'h5, '0, 1'b0, dout);
        for (int i = 0; i < 5; i++) step(1, 0);
        check("tms_abort_tlr", clr_a, 1);
        check("tms_abort_ir", ir_a, 5'h01);
        check("tms_abort_sel", sel_a, 0);
        step(0, 0);

        // Abort a DR scan with trst_n for one edge.
        ir_scan(0, 5, 64'h11, dout);
        step(1, 0); step(0, 0); step(0, 0);
        n_upd_a = 0;
        shift(0, 3, 64'h5, '0, 1'b0, dout);
        trst_n = 1'b0;
        step(0, 0);
        check("trst_abort_tlr", clr_a, 1);
        check("trst_abort_ir", ir_a, 5'h01);
        check("trst_abort_no_update", n_upd_a, 0);
        trst_n = 1'b1;
        step(0, 0);
        check("trst_back_rti", rti_b, 1);

        // Variant: IDCODE scan split by a Pause-DR/Exit2-DR detour.
        step(1, 0); step(0, 0); step(0, 0);
        shift(1, 20, 64'hA5C3E, '0, 1'b1, dout);
        step(0, 0); step(0, 0); step(1, 0); step(0, 0);
        check("pause_resume_shift", sh_b, 1);
        shift(1, 44, 64'hB7D, '0, 1'b1, dout2);
        step(1, 0); step(0, 0);
        dout = {dout2[43:0], dout[19:0]};
        check("pause_idcode_b", dout[31:0], 32'hCAFE_F00D);
        check("pause_echo_b", dout[63:32], 32'hB7DA_5C3E);

        // Variant: highest user DR.
        ir_scan(1, 8, 64'h23, dout);
        check("ir_capture_b", dout, 64'h01);
        check("ir_23", ir_b, 8'h23);
        check("sel_dr3", sel_b, 4'b1000);
        dr_scan(1, 8, '0, 64'h96, dout);
        check("user_dr3_tdo", dout, 64'h96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
